acs_path_metric_unit: RTL and testbench

- Add-Compare-Select stage for the 4-state, rate-1/2, K=3 (generators 7,5 octal) hard-decision Viterbi decoder.
- Takes one received 2-bit symbol per accepted cycle and computes Hamming branch metrics.
- Updates, normalises and saturates the four path metrics.
- Drives the metrics plus a valid strobe directly into the survivor path memory unit downstream, and exports per-state survivor decision bits.

---
 rtl/acs_path_metric_unit.sv | 125 ++++++++++++
 tb/tb_acs_path_metric_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/acs_path_metric_unit.sv
// Add-Compare-Select stage of the K=3 (7,5) hard-decision Viterbi decoder.
// Keeps four normalised, saturated path metrics and per-state decisions.
module acs_path_metric_unit #(
    parameter int PM_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [1:0]       i_sym,
    output logic [PM_W-1:0]  o_PM_0,
    output logic [PM_W-1:0]  o_PM_1,
    output logic [PM_W-1:0]  o_PM_2,
    output logic [PM_W-1:0]  o_PM_3,
    output logic [3:0]       o_dec,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_sym_cnt
);
    localparam int CW = PM_W + 2;
    localparam logic [PM_W-1:0]  PM_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [PM_W-1:0]  pm_q [4];
    logic [PM_W-1:0]  pm_d [4];
    logic [3:0]       dec_q;
    logic [3:0]       dec_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CW-1:0]    old_m [4];
    logic [CW-1:0]    cand_a [4];
    logic [CW-1:0]    cand_b [4];
    logic [CW-1:0]    surv [4];
    logic [CW-1:0]    norm [4];
    logic [CW-1:0]    min_s;
    logic             accept;

    function automatic logic [CW-1:0] bm(input logic [1:0] s,
                                         input logic [1:0] e);
        return CW'(s[1] ^ e[1]) + CW'(s[0] ^ e[0]);
    endfunction

    always_comb begin
        accept = i_valid & (i_start | (state_q == RUN));
        // A start in the same cycle replaces the stored metrics as "old".
        for (int i = 0; i < 4; i++) begin
            if (i_start)
                old_m[i] = (i == 0) ? '0 : CW'(PM_MAX);
            else
                old_m[i] = CW'(pm_q[i]);
        end
        cand_a[0] = old_m[0] + bm(i_sym, 2'b00);
        cand_b[0] = old_m[1] + bm(i_sym, 2'b11);
        cand_a[2] = old_m[0] + bm(i_sym, 2'b11);
        cand_b[2] = old_m[1] + bm(i_sym, 2'b00);
        cand_a[1] = old_m[2] + bm(i_sym, 2'b10);
        cand_b[1] = old_m[3] + bm(i_sym, 2'b01);
        cand_a[3] = old_m[2] + bm(i_sym, 2'b01);
        cand_b[3] = old_m[3] + bm(i_sym, 2'b10);
        for (int i = 0; i < 4; i++) begin
            dec_d[i] = cand_b[i] < cand_a[i];
            surv[i]  = dec_d[i] ? cand_b[i] : cand_a[i];
        end
        min_s = surv[0];
        for (int i = 1; i < 4; i++) begin
            if (surv[i] < min_s)
                min_s = surv[i];
        end
        for (int i = 0; i < 4; i++) begin
            norm[i] = surv[i] - min_s;
            pm_d[i] = (norm[i] > CW'(PM_MAX)) ? PM_MAX : norm[i][PM_W-1:0];
        end
        if (i_start)
            cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pm_q[0] <= '0;
            pm_q[1] <= PM_MAX;
            pm_q[2] <= PM_MAX;
            pm_q[3] <= PM_MAX;
            dec_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= accept;
            unique case (state_q)
                IDLE:    if (i_start) state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                for (int i = 0; i < 4; i++) pm_q[i] <= pm_d[i];
                dec_q <= dec_d;
                cnt_q <= cnt_d;
            end else if (i_start) begin
                pm_q[0] <= '0;
                pm_q[1] <= PM_MAX;
                pm_q[2] <= PM_MAX;
                pm_q[3] <= PM_MAX;
                dec_q   <= '0;
                cnt_q   <= '0;
            end
        end
    end

    assign o_PM_0    = pm_q[0];
    assign o_PM_1    = pm_q[1];
    assign o_PM_2    = pm_q[2];
    assign o_PM_3    = pm_q[3];
    assign o_dec     = dec_q;
    assign o_valid   = valid_q;
    assign o_sym_cnt = cnt_q;

endmodule

// File: tb/tb_acs_path_metric_unit.sv
// Bench for the Viterbi ACS stage: directed trellis steps plus a random
// symbol stream against a convolutional-code reference model.
module tb_acs_path_metric_unit;
    localparam int MAX = 3;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_valid;
    logic [1:0] i_sym;
    logic [1:0] pm0, pm1, pm2, pm3;
    logic [1:0] pm0b, pm1b, pm2b, pm3b;
    logic [3:0] dec, decb;
    logic       vld, vldb;
    logic [7:0] cnt;
    logic [1:0] cntb;

    int n_assert = 0;
    int n_fail   = 0;

    int         pm_m [4];
    logic [3:0] dec_m;
    bit         val_m;
    int         cnt_m, cnt2_m;
    bit         run_m;

    acs_path_metric_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_valid(i_valid), .i_sym(i_sym),
        .o_PM_0(pm0), .o_PM_1(pm1), .o_PM_2(pm2), .o_PM_3(pm3),
        .o_dec(dec), .o_valid(vld), .o_sym_cnt(cnt)
    );

    acs_path_metric_unit #(.PM_W(2), .CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_valid(i_valid), .i_sym(i_sym),
        .o_PM_0(pm0b), .o_PM_1(pm1b), .o_PM_2(pm2b), .o_PM_3(pm3b),
        .o_dec(decb), .o_valid(vldb), .o_sym_cnt(cntb)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] pk(int a, int b, int c, int d);
        return {a[1:0], b[1:0], c[1:0], d[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pm_m   = '{0, MAX, MAX, MAX};
        dec_m  = '0;
        val_m  = 0;
        cnt_m  = 0;
        cnt2_m = 0;
        run_m  = 0;
    endtask

    // Trellis from the encoder itself: state {b1,b2}, c0=u^b1^b2, c1=u^b2.
    task automatic model_step(input bit st, input bit v, input logic [1:0] sym);
        int old [4];
        int nw [4];
        int mn;
        if (st) old = '{0, MAX, MAX, MAX};
        else    old = pm_m;
        val_m = v && (run_m || st);
        if (val_m) begin
            for (int ns = 0; ns < 4; ns++) begin
                int best;
                best = -1;
                for (int k = 0; k < 2; k++) begin
                    int p, u, b1, b2, c0, c1, cost;
                    p    = (ns & 1) * 2 + k;
                    u    = ns >> 1;
                    b1   = (p >> 1) & 1;
                    b2   = p & 1;
                    c0   = u ^ b1 ^ b2;
                    c1   = u ^ b2;
                    cost = old[p] + (c0 ^ int'(sym[1])) + (c1 ^ int'(sym[0]));
                    if (best < 0 || cost < best) begin
                        best      = cost;
                        dec_m[ns] = (k == 1);
                    end
                end
                nw[ns] = best;
            end
            mn = nw[0];
            for (int i = 1; i < 4; i++) if (nw[i] < mn) mn = nw[i];
            for (int i = 0; i < 4; i++)
                pm_m[i] = (nw[i] - mn > MAX) ? MAX : nw[i] - mn;
            cnt_m  = st ? 1 : ((cnt_m < 255) ? cnt_m + 1 : 255);
            cnt2_m = st ? 1 : ((cnt2_m < 3) ? cnt2_m + 1 : 3);
        end else if (st) begin
            pm_m   = old;
            dec_m  = '0;
            cnt_m  = 0;
            cnt2_m = 0;
        end
        if (st) run_m = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pm"}, 32'(pk(pm0, pm1, pm2, pm3)),
            32'(pk(pm_m[0], pm_m[1], pm_m[2], pm_m[3])));
        chk({tag, "_dec"}, 32'(dec), 32'(dec_m));
        chk({tag, "_vld"}, 32'(vld), 32'(val_m));
        chk({tag, "_cnt"}, 32'(cnt), 32'(cnt_m));
        chk({tag, "_cnt2"}, 32'(cntb), 32'(cnt2_m));
    endtask

    task automatic step(input bit st, input bit v, input logic [1:0] sym,
                        input string tag);
        @(negedge i_clk);
        i_start = st;
        i_valid = v;
        i_sym   = sym;
        @(posedge i_clk);
        model_step(st, v, sym);
        #1 check_all(tag);
    endtask

    initial begin
        int exp_c2 [5];
        int mn;
        exp_c2  = '{1, 2, 3, 3, 3};
        i_rst_n = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_sym   = 2'b00;
        #1 i_rst_n = 1'b0;
        model_reset();
        #2 check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        step(0, 1, 2'b11, "t3_idle");
        chk("t3_pm", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(0, 3, 3, 3)));
        chk("t3_vld", 32'(vld), 0);

        step(1, 0, 2'b00, "t1_start");
        step(0, 1, 2'b00, "t1_s00");
        chk("t1_pm", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(0, 3, 2, 3)));
        chk("t1_dec", 32'(dec), 0);
        chk("t1_cnt", 32'(cnt), 1);
        step(0, 0, 2'b00, "t1_gap");
        chk("t1_pulse", 32'(vld), 0);
        step(0, 1, 2'b00, "t1_s00b");
        chk("t1_pm2", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(0, 3, 2, 3)));

        step(1, 0, 2'b00, "t2_start");
        step(0, 1, 2'b11, "t2_a");
        chk("t2_pm_a", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(2, 3, 0, 3)));
        step(0, 1, 2'b10, "t2_b");
        chk("t2_pm_b", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(3, 0, 3, 2)));
        chk("t2_dec_b", 32'(dec), 0);
        step(0, 1, 2'b11, "t2_c");
        chk("t2_pm_c", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(0, 3, 2, 3)));
        chk("t2_dec_c", 32'(dec), 32'hf);
        chk("t2_cnt", 32'(cnt), 3);

        step(1, 1, 2'b11, "t4_restart");
        chk("t4_pm", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(2, 3, 0, 3)));
        chk("t4_vld", 32'(vld), 1);
        chk("t4_cnt", 32'(cnt), 1);

        step(0, 1, 2'b10, "t5_pre");
        @(negedge i_clk);
        i_valid = 1'b0;
        #1 i_rst_n = 1'b0;
        model_reset();
        #1 check_all("t5_rst");
        chk("t5_pm", 32'(pk(pm0, pm1, pm2, pm3)), 32'(pk(0, 3, 3, 3)));
        #2 i_rst_n = 1'b1;
        step(0, 1, 2'b11, "t5_ign");
        chk("t5_ign_vld", 32'(vld), 0);

        step(1, 0, 2'b00, "t6_start");
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 2'(i), "t6_sym");
            chk("t6_cnt2", 32'(cntb), 32'(exp_c2[i]));
        end

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), "rnd");
            mn = pm0;
            if (pm1 < mn) mn = pm1;
            if (pm2 < mn) mn = pm2;
            if (pm3 < mn) mn = pm3;
            chk("rnd_min0", 32'(mn), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
